iob_cache_ctrl_csr: RTL and testbench



---
 rtl/iob_cache_ctrl_csr_if.sv | 23 ++
 rtl/iob_cache_ctrl_csr.sv | 170 +++++++++++++++++
 tb/tb_iob_cache_ctrl_csr.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_cache_ctrl_csr_if.sv
// Register-access bus between the cache control-space front-end and the CSR block.
// Single-cycle request/acknowledge; no stall.
interface iob_cache_ctrl_csr_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output valid, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  valid, we, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/iob_cache_ctrl_csr.sv
// Cache control/status registers: hit/miss event counters with overflow flags,
// counter control, write-through buffer status and a handshaked invalidate request.
module iob_cache_ctrl_csr #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned CNT_W        = 32,
    parameter bit          USE_CTRL_CNT = 1'b1,
    parameter bit          SATURATE     = 1'b1,
    parameter logic [31:0] VERSION      = 32'h0000_0100
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    iob_cache_ctrl_csr_if.slave  bus,
    input  logic                 read_hit_i,
    input  logic                 read_miss_i,
    input  logic                 write_hit_i,
    input  logic                 write_miss_i,
    input  logic                 wtbuf_empty_i,
    input  logic                 wtbuf_full_i,
    output logic                 invalidate_o,
    input  logic                 invalidate_done_i
);

    localparam int unsigned SumW = DATA_W + 1;

    localparam logic [ADDR_W-1:0] AddrHit       = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] AddrMiss      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AddrReadHit   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] AddrReadMiss  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] AddrWriteHit  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] AddrWriteMiss = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] AddrCtrl      = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] AddrInv       = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] AddrStatus    = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] AddrVersion   = ADDR_W'(9);

    typedef enum logic [0:0] {StIdle, StBusy} inv_state_e;

    inv_state_e state_q, state_d;

    // Counter index order: 0 read_hit, 1 read_miss, 2 write_hit, 3 write_miss.
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    logic [3:0]        ovf_q, ovf_d;
    logic              cnt_en_q, cnt_en_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q;

    logic [3:0]        ev;
    logic              wr, wr_ctrl, wr_inv, wr_status, rst_cnt, inv_busy;
    logic [CNT_W:0]    hit_sum, miss_sum;
    logic [SumW-1:0]   hit_wide, miss_wide;
    logic [DATA_W-1:0] hit_rd, miss_rd;
    logic              unused_wdata;

    assign ev        = {write_miss_i, write_hit_i, read_miss_i, read_hit_i};
    assign wr        = bus.valid & bus.we;
    assign wr_ctrl   = wr && (bus.addr == AddrCtrl);
    assign wr_inv    = wr && (bus.addr == AddrInv);
    assign wr_status = wr && (bus.addr == AddrStatus);
    assign rst_cnt   = wr_ctrl & bus.wdata[1];
    assign inv_busy  = (state_q == StBusy);

    assign unused_wdata = ^bus.wdata;

    always_comb begin
        cnt_en_d = cnt_en_q;
        if (wr_ctrl && USE_CTRL_CNT) begin
            cnt_en_d = bus.wdata[0];
        end
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (wr_status && bus.wdata[3+i]) begin
                ovf_d[i] = 1'b0;
            end
            // A counter clear swallows same-cycle events, so they cannot flag overflow.
            if (rst_cnt) begin
                cnt_d[i] = '0;
            end else if (cnt_en_q && ev[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                    if (!SATURATE) begin
                        cnt_d[i] = '0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            if (!USE_CTRL_CNT) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end
        end
    end

    // Sums carry one extra bit; only when CNT_W == DATA_W can it spill past the bus.
    always_comb begin
        hit_sum   = {1'b0, cnt_q[0]} + {1'b0, cnt_q[2]};
        miss_sum  = {1'b0, cnt_q[1]} + {1'b0, cnt_q[3]};
        hit_wide  = SumW'(hit_sum);
        miss_wide = SumW'(miss_sum);
        hit_rd    = (SATURATE && hit_wide[DATA_W]) ? '1 : hit_wide[DATA_W-1:0];
        miss_rd   = (SATURATE && miss_wide[DATA_W]) ? '1 : miss_wide[DATA_W-1:0];
    end

    always_comb begin
        rdata_d = '0;
        if (bus.valid && !bus.we) begin
            case (bus.addr)
                AddrHit:       rdata_d = hit_rd;
                AddrMiss:      rdata_d = miss_rd;
                AddrReadHit:   rdata_d = DATA_W'(cnt_q[0]);
                AddrReadMiss:  rdata_d = DATA_W'(cnt_q[1]);
                AddrWriteHit:  rdata_d = DATA_W'(cnt_q[2]);
                AddrWriteMiss: rdata_d = DATA_W'(cnt_q[3]);
                AddrCtrl:      rdata_d = DATA_W'(cnt_en_q && USE_CTRL_CNT);
                AddrStatus:    rdata_d = DATA_W'({ovf_q, inv_busy, wtbuf_full_i, wtbuf_empty_i});
                AddrVersion:   rdata_d = DATA_W'(VERSION);
                default:       rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q    <= '0;
            cnt_en_q <= 1'b1;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q    <= ovf_d;
            cnt_en_q <= cnt_en_d;
            rdata_q  <= rdata_d;
            ready_q  <= bus.valid;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests while busy are acknowledged on the bus but not queued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (wr_inv) state_d = StBusy;
            StBusy:  if (invalidate_done_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        invalidate_o = (state_q == StBusy);
    end

endmodule

// File: tb/tb_iob_cache_ctrl_csr.sv
// Directed bench: default build, two 4-bit-counter builds (saturating and wrapping)
// and a counter-less build, all driven with identical stimulus.
module tb_iob_cache_ctrl_csr;

    logic clk = 1'b0;
    logic reset_n;
    logic rh, rm, wh, wm;
    logic wt_empty, wt_full, done;
    logic inv0, inv1, inv2, inv3;

    always #5 clk = ~clk;

    iob_cache_ctrl_csr_if #(.DATA_W(32), .ADDR_W(4)) b0 ();
    iob_cache_ctrl_csr_if #(.DATA_W(32), .ADDR_W(4)) b1 ();
    iob_cache_ctrl_csr_if #(.DATA_W(32), .ADDR_W(4)) b2 ();
    iob_cache_ctrl_csr_if #(.DATA_W(32), .ADDR_W(4)) b3 ();

    iob_cache_ctrl_csr dut0 (
        .clk_i(clk), .reset_n_i(reset_n), .bus(b0),
        .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
        .wtbuf_empty_i(wt_empty), .wtbuf_full_i(wt_full),
        .invalidate_o(inv0), .invalidate_done_i(done)
    );

    iob_cache_ctrl_csr #(.CNT_W(4), .SATURATE(1'b1)) dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .bus(b1),
        .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
        .wtbuf_empty_i(wt_empty), .wtbuf_full_i(wt_full),
        .invalidate_o(inv1), .invalidate_done_i(done)
    );

    iob_cache_ctrl_csr #(.CNT_W(4), .SATURATE(1'b0)) dut2 (
        .clk_i(clk), .reset_n_i(reset_n), .bus(b2),
        .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
        .wtbuf_empty_i(wt_empty), .wtbuf_full_i(wt_full),
        .invalidate_o(inv2), .invalidate_done_i(done)
    );

    iob_cache_ctrl_csr #(.USE_CTRL_CNT(1'b0)) dut3 (
        .clk_i(clk), .reset_n_i(reset_n), .bus(b3),
        .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
        .wtbuf_empty_i(wt_empty), .wtbuf_full_i(wt_full),
        .invalidate_o(inv3), .invalidate_done_i(done)
    );

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        int          dut;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] rd [4];
    logic        rdy[4];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [3:0] a,
                         input logic [31:0] d);
        b0.valid = v; b0.we = w; b0.addr = a; b0.wdata = d;
        b1.valid = v; b1.we = w; b1.addr = a; b1.wdata = d;
        b2.valid = v; b2.we = w; b2.addr = a; b2.wdata = d;
        b3.valid = v; b3.we = w; b3.addr = a; b3.wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rd[0] = b0.rdata; rd[1] = b1.rdata; rd[2] = b2.rdata; rd[3] = b3.rdata;
        rdy[0] = b0.ready; rdy[1] = b1.ready; rdy[2] = b2.ready; rdy[3] = b3.ready;
    endtask

    task automatic access(input logic w, input logic [3:0] a, input logic [31:0] d);
        drive(1'b1, w, a, d);
        tick();
        drive(1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic add(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input int dut, input logic [31:0] exp);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.dut = dut; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            access(tbl[i].we, tbl[i].addr, tbl[i].wdata);
            check($sformatf("%s[%0d] ready dut%0d a%0d", tag, i, tbl[i].dut, tbl[i].addr),
                  {31'd0, rdy[tbl[i].dut]}, 32'd1);
            check($sformatf("%s[%0d] rdata dut%0d a%0d", tag, i, tbl[i].dut, tbl[i].addr),
                  rd[tbl[i].dut], tbl[i].exp);
        end
        tbl.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        {rh, rm, wh, wm} = 4'b0;
        wt_empty = 1'b1; wt_full = 1'b0; done = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'd0);
        #12;
        check("reset ready", {31'd0, b0.ready}, 32'd0);
        check("reset rdata", b0.rdata, 32'd0);
        check("reset invalidate", {31'd0, inv0}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Post-reset register map
        for (int a = 0; a < 6; a++) add(1'b0, 4'(a), 32'd0, 0, 32'd0);
        add(1'b0, 4'd6, 32'd0, 0, 32'd1);
        add(1'b0, 4'd7, 32'd0, 0, 32'd0);
        add(1'b0, 4'd8, 32'd0, 0, 32'd1);
        add(1'b0, 4'd9, 32'd0, 0, 32'h0000_0100);
        add(1'b0, 4'd10, 32'd0, 0, 32'd0);
        add(1'b0, 4'd6, 32'd0, 3, 32'd0);
        add(1'b0, 4'd9, 32'd0, 3, 32'h0000_0100);
        run_table("reset_map");

        // Back-to-back reads: one acknowledge per cycle, then ready drops
        drive(1'b1, 1'b0, 4'd9, 32'd0);
        tick();
        check("b2b first", rd[0], 32'h0000_0100);
        drive(1'b1, 1'b0, 4'd6, 32'd0);
        tick();
        check("b2b second", rd[0], 32'd1);
        check("b2b second ready", {31'd0, rdy[0]}, 32'd1);
        drive(1'b0, 1'b0, 4'd0, 32'd0);
        tick();
        check("idle ready", {31'd0, rdy[0]}, 32'd0);
        check("idle rdata", rd[0], 32'd0);

        // Simultaneous events for 3 cycles; read in the 3rd sees the pre-update value
        {rh, rm, wh, wm} = 4'b1111;
        tick();
        tick();
        drive(1'b1, 1'b0, 4'd2, 32'd0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 32'd0);
        {rh, rm, wh, wm} = 4'b0;
        check("read during event", rd[0], 32'd2);
        for (int a = 2; a < 6; a++) add(1'b0, 4'(a), 32'd0, 0, 32'd3);
        add(1'b0, 4'd0, 32'd0, 0, 32'd6);
        add(1'b0, 4'd1, 32'd0, 0, 32'd6);
        add(1'b0, 4'd2, 32'd0, 1, 32'd3);
        add(1'b0, 4'd0, 32'd0, 3, 32'd0);
        add(1'b0, 4'd2, 32'd0, 3, 32'd0);
        run_table("simul");

        // 14 more read hits: 17 in total
        rh = 1'b1;
        repeat (14) tick();
        rh = 1'b0;
        add(1'b0, 4'd2, 32'd0, 0, 32'd17);
        add(1'b0, 4'd8, 32'd0, 0, 32'd1);
        add(1'b0, 4'd2, 32'd0, 1, 32'd15);
        add(1'b0, 4'd8, 32'd0, 1, 32'h9);
        add(1'b0, 4'd0, 32'd0, 1, 32'd18);
        add(1'b0, 4'd2, 32'd0, 2, 32'd1);
        add(1'b0, 4'd8, 32'd0, 2, 32'h9);
        add(1'b0, 4'd0, 32'd0, 2, 32'd4);
        add(1'b0, 4'd8, 32'd0, 3, 32'd1);
        add(1'b1, 4'd8, 32'h8, 1, 32'd0);
        add(1'b0, 4'd8, 32'd0, 1, 32'h1);
        add(1'b0, 4'd8, 32'd0, 2, 32'h1);
        run_table("ovf");

        // Overflow set and W1C in the same cycle: set wins
        rh = 1'b1;
        drive(1'b1, 1'b1, 4'd8, 32'h8);
        tick();
        drive(1'b0, 1'b0, 4'd0, 32'd0);
        rh = 1'b0;
        add(1'b0, 4'd8, 32'd0, 1, 32'h9);
        add(1'b0, 4'd8, 32'd0, 2, 32'h1);
        add(1'b0, 4'd2, 32'd0, 2, 32'd2);
        add(1'b0, 4'd2, 32'd0, 0, 32'd18);
        run_table("setwins");

        // Counter clear with a same-cycle write_hit
        wh = 1'b1;
        drive(1'b1, 1'b1, 4'd6, 32'h3);
        tick();
        drive(1'b0, 1'b0, 4'd0, 32'd0);
        wh = 1'b0;
        check("write ack rdata", rd[0], 32'd0);
        check("write ack ready", {31'd0, rdy[0]}, 32'd1);
        add(1'b0, 4'd4, 32'd0, 0, 32'd0);
        add(1'b0, 4'd2, 32'd0, 0, 32'd0);
        add(1'b0, 4'd0, 32'd0, 0, 32'd0);
        add(1'b0, 4'd6, 32'd0, 0, 32'd1);
        add(1'b0, 4'd8, 32'd0, 1, 32'h9);
        add(1'b1, 4'd6, 32'd0, 0, 32'd0);
        run_table("rstcnt");

        // Counting disabled
        {rh, rm, wh, wm} = 4'b1111;
        repeat (5) tick();
        {rh, rm, wh, wm} = 4'b0;
        for (int a = 0; a < 6; a++) add(1'b0, 4'(a), 32'd0, 0, 32'd0);
        add(1'b0, 4'd6, 32'd0, 0, 32'd0);
        add(1'b1, 4'd6, 32'd1, 0, 32'd0);
        run_table("disabled");

        // Invalidate handshake
        check("inv idle", {31'd0, inv0}, 32'd0);
        access(1'b1, 4'd7, 32'd0);
        check("inv set", {31'd0, inv0}, 32'd1);
        check("inv set nocnt", {31'd0, inv3}, 32'd1);
        access(1'b0, 4'd8, 32'd0);
        check("inv busy status", rd[0], 32'h5);
        access(1'b1, 4'd7, 32'd0);
        check("inv second write", {31'd0, inv0}, 32'd1);
        check("inv second ack", {31'd0, rdy[0]}, 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("inv done", {31'd0, inv0}, 32'd0);
        check("inv done nocnt", {31'd0, inv3}, 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("done in idle", {31'd0, inv0}, 32'd0);
        wt_empty = 1'b0; wt_full = 1'b1;
        access(1'b0, 4'd8, 32'd0);
        check("wtbuf full status", rd[0], 32'h2);
        wt_empty = 1'b1; wt_full = 1'b0;

        // Asynchronous reset while busy with nonzero counters
        rh = 1'b1;
        tick();
        tick();
        rh = 1'b0;
        access(1'b1, 4'd7, 32'd0);
        drive(1'b1, 1'b0, 4'd2, 32'd0);
        tick();
        check("pre-reset rdata", rd[0], 32'd2);
        check("pre-reset inv", {31'd0, inv0}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset inv", {31'd0, inv0}, 32'd0);
        check("async reset ready", {31'd0, b0.ready}, 32'd0);
        check("async reset rdata", b0.rdata, 32'd0);
        drive(1'b0, 1'b0, 4'd0, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        add(1'b0, 4'd2, 32'd0, 0, 32'd0);
        add(1'b0, 4'd8, 32'd0, 0, 32'd1);
        add(1'b0, 4'd6, 32'd0, 0, 32'd1);
        run_table("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
